// File: rtl/tt_sel_seq.sv
// tt_sel_seq: host-side selection sequencer driving the controller's sel_rst_n/sel_inc/ena pads.
// Ports: clk, rst (sync, active-high); req/addr in with ack out form the request handshake;
//   dis drops ena and returns to idle; busy/done report progress; sel_rst_n, sel_inc, ena drive the pads.
// Optional feature: define TT_SEL_INCREMENTAL_EN to step forward from the current address without a counter reset.
module tt_sel_seq #(
  parameter int ADDR_W  = 10,
  parameter int RST_CYC = 4,
  parameter int INC_HI  = 2,
  parameter int INC_LO  = 2,
  parameter int ENA_DLY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              dis,
  output logic              ack,
  output logic              busy,
  output logic              done,
  output logic              sel_rst_n,
  output logic              sel_inc,
  output logic              ena
);
  localparam int CW = $clog2(RST_CYC + INC_HI + INC_LO + ENA_DLY + 1);
  localparam logic [CW-1:0] T_RST = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] T_HI  = CW'(INC_HI - 1);
  localparam logic [CW-1:0] T_LO  = CW'(INC_LO - 1);
  localparam logic [CW-1:0] T_ENA = CW'(ENA_DLY - 1);
  typedef enum logic [2:0] {S_IDLE, S_RST, S_GAP, S_INC_HI, S_INC_LO, S_SETTLE, S_ACTIVE} state_t;
  state_t st, nxt;
  logic [CW-1:0] tmr, tmr_n;
  logic [ADDR_W-1:0] pcnt, pcnt_n;
  logic ack_n, done_n;
`ifdef TT_SEL_INCREMENTAL_EN
  logic [ADDR_W-1:0] tgt, tgt_n, cur, cur_n;
  logic cv, cv_n;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_IDLE;
      tmr       <= '0;
      pcnt      <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sel_rst_n <= 1'b0;
      sel_inc   <= 1'b0;
      ena       <= 1'b0;
`ifdef TT_SEL_INCREMENTAL_EN
      tgt       <= '0;
      cur       <= '0;
      cv        <= 1'b0;
`endif
    end else begin
      st        <= nxt;
      tmr       <= tmr_n;
      pcnt      <= pcnt_n;
      ack       <= ack_n;
      done      <= done_n;
      busy      <= nxt != S_IDLE && nxt != S_ACTIVE;
      sel_rst_n <= nxt != S_IDLE && nxt != S_RST;
      sel_inc   <= nxt == S_INC_HI;
      ena       <= nxt == S_ACTIVE;
`ifdef TT_SEL_INCREMENTAL_EN
      tgt       <= tgt_n;
      cur       <= cur_n;
      cv        <= cv_n;
`endif
    end
  end
  // tmr counts down the cycles left in timed states; every entry reloads it, so idle underflow is harmless
  always_comb begin
    nxt    = st;
    tmr_n  = tmr - 1'b1;
    pcnt_n = pcnt;
    ack_n  = 1'b0;
    done_n = 1'b0;
`ifdef TT_SEL_INCREMENTAL_EN
    tgt_n  = tgt;
    cur_n  = cur;
    cv_n   = cv;
`endif
    if (dis) begin
      nxt = S_IDLE;
`ifdef TT_SEL_INCREMENTAL_EN
      cv_n = 1'b0;
`endif
    end else begin
      case (st)
        S_IDLE, S_ACTIVE: if (req) begin
          ack_n  = 1'b1;
          nxt    = S_RST;
          tmr_n  = T_RST;
          pcnt_n = addr;
`ifdef TT_SEL_INCREMENTAL_EN
          tgt_n  = addr;
          if (st == S_ACTIVE && cv && addr >= cur) begin
            pcnt_n = addr - cur;
            nxt    = addr == cur ? S_SETTLE : S_INC_HI;
            tmr_n  = addr == cur ? T_ENA : T_HI;
          end
`endif
        end
        S_RST: if (tmr == '0) nxt = S_GAP;
        S_GAP: begin
          nxt   = pcnt == '0 ? S_SETTLE : S_INC_HI;
          tmr_n = pcnt == '0 ? T_ENA : T_HI;
        end
        S_INC_HI: if (tmr == '0) begin
          nxt   = S_INC_LO;
          tmr_n = T_LO;
        end
        S_INC_LO: if (tmr == '0) begin
          pcnt_n = pcnt - 1'b1;
          nxt    = pcnt == ADDR_W'(1) ? S_SETTLE : S_INC_HI;
          tmr_n  = pcnt == ADDR_W'(1) ? T_ENA : T_HI;
        end
        S_SETTLE: if (tmr == '0) begin
          nxt    = S_ACTIVE;
          done_n = 1'b1;
`ifdef TT_SEL_INCREMENTAL_EN
          cur_n  = tgt;
          cv_n   = 1'b1;
`endif
        end
        default: nxt = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tt_sel_seq.sv
// tb_tt_sel_seq: self-checking bench for tt_sel_seq against a cycle-indexed waveform model.
module tb_tt_sel_seq;
  localparam int ADDR_W = 10, RST_CYC = 4, INC_HI = 2, INC_LO = 2, ENA_DLY = 2;
  localparam int P = INC_HI + INC_LO;
  logic clk = 1'b0;
  logic rst, req, dis;
  logic [ADDR_W-1:0] addr;
  logic ack, busy, done, sel_rst_n, sel_inc, ena;
  int total = 0, passed = 0, fails = 0;
  int cur = -1;
  tt_sel_seq #(.ADDR_W(ADDR_W), .RST_CYC(RST_CYC), .INC_HI(INC_HI), .INC_LO(INC_LO), .ENA_DLY(ENA_DLY)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .dis(dis), .ack(ack), .busy(busy),
    .done(done), .sel_rst_n(sel_rst_n), .sel_inc(sel_inc), .ena(ena)
  );
  always #5 clk = ~clk;
  function automatic logic [5:0] obs();
    return {ack, busy, done, sel_rst_n, sel_inc, ena};
  endfunction
  task automatic chk(input string tag, input int k, input logic [5:0] exp);
    total++;
    assert (obs() === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s k=%0d: observed {ack,busy,done,rst_n,inc,ena}=%b expected %b", tag, k, obs(), exp);
    end
  endtask
  // Expected pad waveform for one request: pre cycles of reset/gap, n pulses of P cycles, ENA_DLY settle.
  task automatic run_seq(input string tag, input int a, input int inj, input int abort);
    int pre, n, len;
    bit full;
    logic [5:0] exp;
`ifdef TT_SEL_INCREMENTAL_EN
    full = !(cur >= 0 && a >= cur);
`else
    full = 1'b1;
`endif
    n = full ? a : a - cur;
    pre = full ? RST_CYC + 1 : 0;
    len = pre + n * P + ENA_DLY;
    req = 1'b1;
    addr = ADDR_W'(a);
    for (int k = 0; k <= len + 2; k++) begin
      if (abort >= 0 && k == pre + abort) rst = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      if (abort >= 0 && k == pre + abort) begin
        rst = 1'b0;
        chk({tag, "_rst"}, k, 6'b0);
        cur = -1;
        return;
      end
      if (inj >= 0 && k + 1 == pre + inj) begin
        req = 1'b1;
        addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      end
      exp = {k == 0, k < len, k == len, full ? k >= RST_CYC : 1'b1,
             k >= pre && k < pre + n * P && ((k - pre) % P) < INC_HI, k >= len};
      chk(tag, k, exp);
    end
    cur = a;
  endtask
  initial begin
    rst = 1'b1;
    req = 1'b0;
    dis = 1'b0;
    addr = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset", i, 6'b0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle", 0, 6'b0);
    run_seq("addr3", 3, -1, -1);
    run_seq("addr0", 0, -1, -1);
    for (int i = 0; i < 6; i++) run_seq("rand", int'($urandom_range(0, 12)), -1, -1);
    run_seq("req_in_inc_hi", 4, 1, -1);
    dis = 1'b1;
    req = 1'b1;
    addr = ADDR_W'(9);
    @(posedge clk);
    #1;
    dis = 1'b0;
    req = 1'b0;
    cur = -1;
    chk("dis_req", 0, 6'b0);
    for (int i = 1; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("dis_idle", i, 6'b0);
    end
    run_seq("pre_abort", 5, -1, 1);
    run_seq("after_abort", 2, -1, -1);
    run_seq("rand_mid", int'($urandom_range(1, 12)), -1, -1);
    dis = 1'b1;
    @(posedge clk);
    #1;
    dis = 1'b0;
    cur = -1;
    chk("dis_active", 0, 6'b0);
    run_seq("addr_max", (1 << ADDR_W) - 1, -1, -1);
    run_seq("sel5", 5, -1, -1);
    run_seq("sel7", 7, -1, -1);
    run_seq("sel7_again", 7, -1, -1);
    run_seq("sel4", 4, -1, -1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
